// File: rtl/riscv_run_sequencer.sv
// Run/step/reset sequencer for a RISC-V core driven by CPU control-register levels.
// Optional macro RISCV_RUN_CYCLE_CNT_EN adds a free-running count of enabled core cycles.
//
// state    | meaning
// RST_HOLD | core held in reset, hold timer counting down
// HALT     | core out of reset, clock-enable off, waiting for run/step
// RUN      | core advancing freely
// STEP     | core advancing until the first retire
// STOP     | core stopped, waiting for bus drain (core_idle)
module riscv_run_sequencer #(
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_run,
    input  logic        ctrl_reset,
    input  logic        ctrl_step,
    input  logic        core_retire,
    input  logic        core_idle,
    output logic        core_rst,
    output logic        core_en,
    output logic        step_done,
    output logic [2:0]  seq_state,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        S_RST_HOLD = 3'd0,
        S_HALT     = 3'd1,
        S_RUN      = 3'd2,
        S_STEP     = 3'd3,
        S_STOP     = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(RESET_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       step_prev_q;
    logic       step_edge;
    logic       core_rst_q, core_rst_d;
    logic       core_en_q, core_en_d;
    logic       step_done_q, step_done_d;

    assign step_edge = ctrl_step & ~step_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST_HOLD;
            hold_cnt_q  <= HOLD_LOAD;
            step_prev_q <= 1'b0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            step_prev_q <= ctrl_step;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            step_done_q <= step_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        step_done_d = 1'b0;
        if (ctrl_reset) begin
            // Core reset request overrides everything, including a pending retire in STEP.
            state_d    = S_RST_HOLD;
            hold_cnt_d = HOLD_LOAD;
        end else begin
            unique case (state_q)
                S_RST_HOLD: begin
                    if (hold_cnt_q <= 8'd1) begin
                        hold_cnt_d = 8'd0;
                        state_d    = S_HALT;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end
                S_HALT: begin
                    if (ctrl_run)       state_d = S_RUN;
                    else if (step_edge) state_d = S_STEP;
                end
                S_RUN: begin
                    if (!ctrl_run) state_d = S_STOP;
                end
                S_STEP: begin
                    if (core_retire) begin
                        state_d     = S_STOP;
                        step_done_d = 1'b1;
                    end
                end
                S_STOP: begin
                    if (core_idle) state_d = S_HALT;
                end
                default: begin
                    state_d    = S_RST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            endcase
        end
        core_rst_d = (state_d == S_RST_HOLD);
        core_en_d  = (state_d == S_RUN) || (state_d == S_STEP);
    end

    assign core_rst  = core_rst_q;
    assign core_en   = core_en_q;
    assign step_done = step_done_q;
    assign seq_state = state_q;

`ifdef RISCV_RUN_CYCLE_CNT_EN
    logic [31:0] run_cycles_q;

    always_ff @(posedge clk) begin
        if (rst)                          run_cycles_q <= 32'd0;
        else if (state_d == S_RST_HOLD)   run_cycles_q <= 32'd0;
        else if (core_en_q)               run_cycles_q <= run_cycles_q + 32'd1;
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_run_sequencer.sv
// Bench for riscv_run_sequencer: directed scenarios then random stimulus, every cycle
// compared against a behavioural model of the sequencing rules.
module tb_riscv_run_sequencer;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst, ctrl_run, ctrl_reset, ctrl_step, core_retire, core_idle;
    logic        core_rst, core_en, step_done;
    logic [2:0]  seq_state;
    logic [31:0] run_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // model state: 0 RST_HOLD, 1 HALT, 2 RUN, 3 STEP, 4 STOP
    int          m_state, m_hold;
    bit          m_prev, m_rst, m_en, m_done;
    logic [31:0] m_cycles;

    int sd_count, en_count;

    riscv_run_sequencer #(.RESET_CYCLES(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_run   (ctrl_run),
        .ctrl_reset (ctrl_reset),
        .ctrl_step  (ctrl_step),
        .core_retire(core_retire),
        .core_idle  (core_idle),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .step_done  (step_done),
        .seq_state  (seq_state),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit edge_seen;
        int next;
        if (rst) begin
            m_state = 0; m_hold = R; m_prev = 0;
            m_rst = 1; m_en = 0; m_done = 0; m_cycles = 0;
            return;
        end
        edge_seen = ctrl_step && !m_prev;
        m_prev = ctrl_step;
        if (m_en) m_cycles = m_cycles + 32'd1;
        m_done = 0;
        next = m_state;
        if (ctrl_reset) begin
            next = 0; m_hold = R; m_cycles = 0;
        end else if (m_state == 0) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) next = 1;
        end else if (m_state == 1) begin
            if (ctrl_run) next = 2;
            else if (edge_seen) next = 3;
        end else if (m_state == 2) begin
            if (!ctrl_run) next = 4;
        end else if (m_state == 3) begin
            if (core_retire) begin next = 4; m_done = 1; end
        end else if (m_state == 4) begin
            if (core_idle) next = 1;
        end
        m_state = next;
        m_rst = (next == 0);
        m_en = (next == 2 || next == 3);
    endtask

    task automatic tick();
        logic [31:0] exp_cycles;
        @(posedge clk);
        model_edge();
        #1;
`ifdef RISCV_RUN_CYCLE_CNT_EN
        exp_cycles = m_cycles;
`else
        exp_cycles = 32'd0;
`endif
        check("seq_state", 32'(seq_state), 32'(m_state));
        check("core_rst", 32'(core_rst), 32'(m_rst));
        check("core_en", 32'(core_en), 32'(m_en));
        check("step_done", 32'(step_done), 32'(m_done));
        check("run_cycles", run_cycles, exp_cycles);
        sd_count += int'(step_done);
        en_count += int'(core_en);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1; ctrl_run = 0; ctrl_reset = 0; ctrl_step = 0; core_retire = 0; core_idle = 1;
        ticks(2);
        check("reset_core_rst", 32'(core_rst), 32'd1);
        check("reset_state", 32'(seq_state), 32'd0);
        rst = 0;
        ticks(3);
        check("hold_core_rst", 32'(core_rst), 32'd1);
        tick();
        check("hold_to_halt", 32'(seq_state), 32'd1);
        check("halt_core_rst", 32'(core_rst), 32'd0);

        // run for 10 cycles then drain
        ctrl_run = 1; en_count = 0;
        ticks(10);
        ctrl_run = 0;
        tick();
        check("run_to_stop", 32'(seq_state), 32'd4);
        tick();
        check("stop_to_halt", 32'(seq_state), 32'd1);
        check("run_en_cycles", 32'(en_count), 32'd10);
`ifdef RISCV_RUN_CYCLE_CNT_EN
        check("run_cycles_10", run_cycles, 32'd10);
`else
        check("run_cycles_off", run_cycles, 32'd0);
`endif

        // single step with a held ctrl_step
        sd_count = 0;
        ctrl_step = 1;
        ticks(3);
        check("step_en", 32'(core_en), 32'd1);
        core_retire = 1;
        tick();
        core_retire = 0;
        check("step_done_pulse", 32'(step_done), 32'd1);
        ticks(6);
        check("step_back_halt", 32'(seq_state), 32'd1);
        check("step_once", 32'(sd_count), 32'd1);
        ctrl_step = 0;
        tick();

        // run + step edge together: run wins, edges in RUN ignored
        sd_count = 0;
        ctrl_run = 1; ctrl_step = 1;
        tick();
        check("run_beats_step", 32'(seq_state), 32'd2);
        ctrl_step = 0; tick();
        ctrl_step = 1; core_retire = 1; tick();
        core_retire = 0; ctrl_step = 0;
        ctrl_run = 0; ticks(3);
        check("no_step_in_run", 32'(sd_count), 32'd0);

        // core reset during a step
        sd_count = 0;
        ctrl_step = 1; tick();
        ctrl_reset = 1; tick();
        check("abort_state", 32'(seq_state), 32'd0);
        check("abort_en", 32'(core_en), 32'd0);
        ctrl_reset = 0; ctrl_step = 0; core_retire = 1;
        ticks(4);
        core_retire = 0;
        check("abort_halt", 32'(seq_state), 32'd1);
        check("abort_no_done", 32'(sd_count), 32'd0);

        // STOP holds while bus busy even with ctrl_run high
        ctrl_run = 1; tick();
        ctrl_run = 0; core_idle = 0; tick();
        ctrl_run = 1;
        ticks(5);
        check("stop_hold", 32'(seq_state), 32'd4);
        core_idle = 1; tick();
        check("drain_halt", 32'(seq_state), 32'd1);
        tick();
        check("halt_run", 32'(seq_state), 32'd2);
        ctrl_run = 0; ticks(2);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            ctrl_reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) ctrl_run = ~ctrl_run;
            if ($urandom_range(0, 3) == 0) ctrl_step = ~ctrl_step;
            core_retire = ($urandom_range(0, 3) == 0);
            core_idle = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_run_sequencer.md
RISCV_RUN_SEQUENCER -- requirements
Module: riscv_run_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 4, giving the number of core-reset hold cycles after ctrl_reset deasserts (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ctrl_run, input, 1 bit: run-request level from the CPU control register.
REQ-005 The block SHALL have port ctrl_reset, input, 1 bit: core-reset-request level from the CPU control register.
REQ-006 The block SHALL have port ctrl_step, input, 1 bit: single-step request from the CPU control register; only its 0->1 edge is significant.
REQ-007 The block SHALL have port core_retire, input, 1 bit: one-cycle pulse per instruction retired by the core.
REQ-008 The block SHALL have port core_idle, input, 1 bit: high when the core has no outstanding bus transaction.
REQ-009 The block SHALL have port core_rst, output, 1 bit: reset to the core.
REQ-010 The block SHALL have port core_en, output, 1 bit: clock enable / advance to the core.
REQ-011 The block SHALL have port step_done, output, 1 bit: one-cycle pulse when a single step completes.
REQ-012 The block SHALL have port seq_state, output, 3 bits: encoding of the current state (RST_HOLD=0, HALT=1, RUN=2, STEP=3, STOP=4).
REQ-013 The block SHALL have port run_cycles, output, 32 bits: count of cycles with core_en=1 (see Configuration).

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The step edge SHALL be the registered previous value of ctrl_step being 0 while the current value is 1; the edge SHALL be acted on only in HALT and otherwise discarded (never queued).
REQ-016 In RST_HOLD: core_rst=1, core_en=0; while ctrl_reset=1 the hold counter reloads RESET_CYCLES; otherwise it decrements; transition to HALT occurs on the cycle the counter reaches 0.
REQ-017 In HALT: core_rst=0, core_en=0; ctrl_run=1 -> RUN; else a step edge -> STEP; ctrl_run=1 together with a step edge -> RUN, with the edge discarded.
REQ-018 In RUN: core_en=1; ctrl_run=0 -> STOP.
REQ-019 In STEP: core_en=1; on the first core_retire=1 -> STOP, with step_done=1 in the cycle after that retire; core_retire SHALL be ignored in every other state.
REQ-020 In STOP: core_en=0; core_idle=1 -> HALT; ctrl_run=1 in STOP SHALL NOT abort the drain.
REQ-021 ctrl_reset=1 SHALL force RST_HOLD from any state on the next edge, overriding every other transition, and SHALL drop core_en in that cycle; any in-progress step SHALL be abandoned and produce no step_done.
REQ-022 step_done SHALL be exactly one cycle wide; it is never asserted outside the STEP->STOP transition.

Reset
REQ-023 On rst=1: state=RST_HOLD, hold counter=RESET_CYCLES, core_rst=1, core_en=0, step_done=0, step edge register=0, run_cycles=0.
REQ-024 After rst is released with ctrl_reset=0, the block SHALL reach HALT exactly RESET_CYCLES cycles later.

Configuration
REQ-025 With macro RISCV_RUN_CYCLE_CNT_EN defined, run_cycles SHALL increment by 1 each cycle core_en=1, wrap from 0xFFFFFFFF to 0, and clear only on rst or on entry to RST_HOLD.
REQ-026 Without RISCV_RUN_CYCLE_CNT_EN, run_cycles SHALL be the constant 0 and the counter SHALL not be implemented.

Verification
REQ-027 rst for 2 cycles, release with ctrl_reset=0 -> core_rst=1 for exactly 4 cycles, then seq_state=1 and core_rst=0.
REQ-028 In HALT, ctrl_run 0->1 for 10 cycles then 0, core_idle=1 -> core_en=1 for 10 cycles, STOP for 1 cycle, HALT; run_cycles=10 with the macro, 0 without it.
REQ-029 In HALT, ctrl_step 0->1, core_retire pulses 3 cycles later -> core_en high until the retire, single step_done pulse, seq_state returns to 1; holding ctrl_step=1 SHALL cause no second step.
REQ-030 In HALT, ctrl_run and a ctrl_step edge in the same cycle -> seq_state=2, no step_done ever; a step edge during RUN is ignored.
REQ-031 In STEP before any retire, ctrl_reset=1 -> next cycle seq_state=0, core_en=0, core_rst=1, no step_done; release -> HALT after 4 cycles.
REQ-032 In STOP with core_idle=0 for 5 cycles and ctrl_run=1 -> stays in STOP with core_en=0; core_idle=1 -> HALT, then RUN on the next cycle.
